// File: rtl/axi_lite_pkg.sv
// Shared types for the AXI4-Lite master engine: FSM states, response codes and
// the latched command record (sized for the widest supported bus).
package axi_lite_pkg;

    localparam int MAX_DATA_W = 64;
    localparam int MAX_ADDR_W = 64;

    typedef logic [1:0] resp_t;
    localparam resp_t OKAY   = 2'b00;
    localparam resp_t SLVERR = 2'b10;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_AW_W = 3'd1,
        WR_B    = 3'd2,
        RD_AR   = 3'd3,
        RD_R    = 3'd4,
        RSP     = 3'd5
    } state_t;

    typedef struct packed {
        logic                    write;
        logic [MAX_ADDR_W-1:0]   addr;
        logic [MAX_DATA_W-1:0]   data;
        logic [MAX_DATA_W/8-1:0] strb;
        logic [MAX_DATA_W-1:0]   mask;
    } cmd_t;

    function automatic logic is_wait_state(input state_t s);
        return (s == WR_AW_W) || (s == WR_B) || (s == RD_AR) || (s == RD_R);
    endfunction

endpackage

// File: rtl/axi_lite_watchdog.sv
// Clearable cycle counter that flags the last permitted cycle of a wait state.
// TIMEOUT_CYCLES = 0 disables it entirely.
module axi_lite_watchdog #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    generate
        if (TIMEOUT_CYCLES == 0) begin : g_off
            logic unused_in;
            assign unused_in = ^{clk, rst_n, clr, en};
            assign expired   = 1'b0;
        end else begin : g_on
            localparam int            CW   = $clog2(TIMEOUT_CYCLES + 1);
            localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

            logic [CW-1:0] cnt_q, cnt_d;

            // Count holds at LAST; the FSM leaves the state on that cycle anyway.
            always_comb begin
                cnt_d = cnt_q;
                if (clr) begin
                    cnt_d = '0;
                end else if (en && (cnt_q != LAST)) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end

            assign expired = en && (cnt_q == LAST);
        end
    endgenerate

endmodule

// File: rtl/axi_lite_master_engine.sv
// Single-beat AXI4-Lite master: write, read and masked read-compare commands,
// one response record per command, per-phase watchdog and saturating error count.
module axi_lite_master_engine
    import axi_lite_pkg::*;
#(
    parameter int C_AXI_DATA_WIDTH = 32,
    parameter int C_AXI_ADDR_WIDTH = 16,
    parameter int TIMEOUT_CYCLES   = 1024,
    parameter int ERR_CNT_WIDTH    = 16
) (
    input  logic                            axi_aclk,
    input  logic                            axi_aresetn,
    // Both ports use valid/ready: a transfer happens on an edge where both are
    // high; a raised valid and its payload stay stable until that edge.
    input  logic                            cmd_valid,
    output logic                            cmd_ready,
    input  logic                            cmd_write,
    input  logic [C_AXI_ADDR_WIDTH-1:0]     cmd_addr,
    input  logic [C_AXI_DATA_WIDTH-1:0]     cmd_data,
    input  logic [C_AXI_DATA_WIDTH/8-1:0]   cmd_strb,
    input  logic [C_AXI_DATA_WIDTH-1:0]     cmd_mask,
    output logic                            rsp_valid,
    input  logic                            rsp_ready,
    output logic [C_AXI_DATA_WIDTH-1:0]     rsp_data,
    output logic [1:0]                      rsp_resp,
    output logic                            rsp_mismatch,
    output logic                            rsp_timeout,
    output logic                            busy,
    output logic [ERR_CNT_WIDTH-1:0]        err_count,
    output logic [2:0]                      dbg_state,
    output logic [C_AXI_ADDR_WIDTH-1:0]     m_axi_awaddr,
    output logic [2:0]                      m_axi_awprot,
    output logic                            m_axi_awvalid,
    input  logic                            m_axi_awready,
    output logic [C_AXI_DATA_WIDTH-1:0]     m_axi_wdata,
    output logic [C_AXI_DATA_WIDTH/8-1:0]   m_axi_wstrb,
    output logic                            m_axi_wvalid,
    input  logic                            m_axi_wready,
    input  logic [1:0]                      m_axi_bresp,
    input  logic                            m_axi_bvalid,
    output logic                            m_axi_bready,
    output logic [C_AXI_ADDR_WIDTH-1:0]     m_axi_araddr,
    output logic [2:0]                      m_axi_arprot,
    output logic                            m_axi_arvalid,
    input  logic                            m_axi_arready,
    input  logic [C_AXI_DATA_WIDTH-1:0]     m_axi_rdata,
    input  logic [1:0]                      m_axi_rresp,
    input  logic                            m_axi_rvalid,
    output logic                            m_axi_rready
);

    localparam int DW = C_AXI_DATA_WIDTH;
    localparam int AW = C_AXI_ADDR_WIDTH;

    state_t                  state_q, state_d;
    cmd_t                    cmd_q, cmd_d;
    logic                    aw_done_q, aw_done_d;
    logic                    w_done_q, w_done_d;
    logic [DW-1:0]           rsp_data_q, rsp_data_d;
    resp_t                   rsp_resp_q, rsp_resp_d;
    logic                    rsp_mismatch_q, rsp_mismatch_d;
    logic                    rsp_timeout_q, rsp_timeout_d;
    logic [ERR_CNT_WIDTH-1:0] err_count_q, err_count_d;
    logic                    timeout_hit;
    logic                    wd_expired;
    logic                    unused_cmd;

    axi_lite_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (axi_aclk),
        .rst_n  (axi_aresetn),
        .clr    (state_d != state_q),
        .en     (is_wait_state(state_q)),
        .expired(wd_expired)
    );

    always_comb begin
        state_d        = state_q;
        cmd_d          = cmd_q;
        aw_done_d      = aw_done_q;
        w_done_d       = w_done_q;
        rsp_data_d     = rsp_data_q;
        rsp_resp_d     = rsp_resp_q;
        rsp_mismatch_d = rsp_mismatch_q;
        rsp_timeout_d  = rsp_timeout_q;
        err_count_d    = err_count_q;
        timeout_hit    = 1'b0;

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    cmd_d              = '0;
                    cmd_d.write        = cmd_write;
                    cmd_d.addr[AW-1:0] = cmd_addr;
                    cmd_d.data[DW-1:0] = cmd_data;
                    cmd_d.strb[DW/8-1:0] = cmd_strb;
                    cmd_d.mask[DW-1:0] = cmd_mask;
                    aw_done_d          = 1'b0;
                    w_done_d           = 1'b0;
                    state_d            = cmd_write ? WR_AW_W : RD_AR;
                end
            end
            WR_AW_W: begin
                aw_done_d = aw_done_q | (m_axi_awvalid & m_axi_awready);
                w_done_d  = w_done_q  | (m_axi_wvalid  & m_axi_wready);
                if (aw_done_d && w_done_d) begin
                    state_d = WR_B;
                end else if (wd_expired) begin
                    timeout_hit = 1'b1;
                end
            end
            WR_B: begin
                if (m_axi_bvalid) begin
                    state_d        = RSP;
                    rsp_data_d     = '0;
                    rsp_resp_d     = m_axi_bresp;
                    rsp_mismatch_d = 1'b0;
                    rsp_timeout_d  = 1'b0;
                end else if (wd_expired) begin
                    timeout_hit = 1'b1;
                end
            end
            RD_AR: begin
                if (m_axi_arready) begin
                    state_d = RD_R;
                end else if (wd_expired) begin
                    timeout_hit = 1'b1;
                end
            end
            RD_R: begin
                if (m_axi_rvalid) begin
                    state_d        = RSP;
                    rsp_data_d     = m_axi_rdata;
                    rsp_resp_d     = m_axi_rresp;
                    rsp_mismatch_d = |((m_axi_rdata ^ cmd_q.data[DW-1:0]) & cmd_q.mask[DW-1:0]);
                    rsp_timeout_d  = 1'b0;
                end else if (wd_expired) begin
                    timeout_hit = 1'b1;
                end
            end
            RSP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A handshake on the limit cycle already moved the FSM on, so it wins.
        if (timeout_hit) begin
            state_d        = RSP;
            rsp_data_d     = '0;
            rsp_resp_d     = SLVERR;
            rsp_mismatch_d = 1'b0;
            rsp_timeout_d  = 1'b1;
        end

        if ((state_d == RSP) && (state_q != RSP) &&
            ((rsp_resp_d != OKAY) || rsp_mismatch_d || rsp_timeout_d) &&
            (err_count_q != '1)) begin
            err_count_d = err_count_q + ERR_CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge axi_aclk) begin
        if (!axi_aresetn) begin
            state_q        <= IDLE;
            cmd_q          <= '0;
            aw_done_q      <= 1'b0;
            w_done_q       <= 1'b0;
            rsp_data_q     <= '0;
            rsp_resp_q     <= OKAY;
            rsp_mismatch_q <= 1'b0;
            rsp_timeout_q  <= 1'b0;
            err_count_q    <= '0;
        end else begin
            state_q        <= state_d;
            cmd_q          <= cmd_d;
            aw_done_q      <= aw_done_d;
            w_done_q       <= w_done_d;
            rsp_data_q     <= rsp_data_d;
            rsp_resp_q     <= rsp_resp_d;
            rsp_mismatch_q <= rsp_mismatch_d;
            rsp_timeout_q  <= rsp_timeout_d;
            err_count_q    <= err_count_d;
        end
    end

    // Direction lives in the state encoding; the latched write bit and the
    // bits above the configured widths are never read.
    assign unused_cmd = ^cmd_q;

    assign cmd_ready     = (state_q == IDLE);
    assign rsp_valid     = (state_q == RSP);
    assign busy          = (state_q != IDLE);
    assign dbg_state     = state_q;
    assign rsp_data      = rsp_data_q;
    assign rsp_resp      = rsp_resp_q;
    assign rsp_mismatch  = rsp_mismatch_q;
    assign rsp_timeout   = rsp_timeout_q;
    assign err_count     = err_count_q;

    assign m_axi_awaddr  = cmd_q.addr[AW-1:0];
    assign m_axi_awprot  = 3'b000;
    assign m_axi_awvalid = (state_q == WR_AW_W) && !aw_done_q;
    assign m_axi_wdata   = cmd_q.data[DW-1:0];
    assign m_axi_wstrb   = cmd_q.strb[DW/8-1:0];
    assign m_axi_wvalid  = (state_q == WR_AW_W) && !w_done_q;
    assign m_axi_bready  = (state_q == WR_B);
    assign m_axi_araddr  = cmd_q.addr[AW-1:0];
    assign m_axi_arprot  = 3'b000;
    assign m_axi_arvalid = (state_q == RD_AR);
    assign m_axi_rready  = (state_q == RD_R);

endmodule

// File: tb/tb_axi_lite_master_engine.sv
// Directed bench for axi_lite_master_engine: scripted slave, cycle-exact checks
// at the falling edge, response scoreboard and saturation of a 2-bit err_count.
module tb_axi_lite_master_engine;
    import axi_lite_pkg::*;

    localparam int DW  = 32;
    localparam int AW  = 16;
    localparam int TO  = 8;
    localparam int ECW = 2;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst_n;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- DUT signals ----------------
    logic            cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0]   cmd_addr;
    logic [DW-1:0]   cmd_data, cmd_mask;
    logic [DW/8-1:0] cmd_strb;
    logic            rsp_valid, rsp_ready, rsp_mismatch, rsp_timeout, busy;
    logic [DW-1:0]   rsp_data;
    logic [1:0]      rsp_resp;
    logic [ECW-1:0]  err_count;
    logic [2:0]      dbg_state;
    logic [AW-1:0]   awaddr, araddr;
    logic [2:0]      awprot, arprot;
    logic            awvalid, awready, wvalid, wready, bvalid, bready;
    logic            arvalid, arready, rvalid, rready;
    logic [DW-1:0]   wdata, rdata;
    logic [DW/8-1:0] wstrb;
    logic [1:0]      bresp, rresp;

    axi_lite_master_engine #(
        .C_AXI_DATA_WIDTH(DW),
        .C_AXI_ADDR_WIDTH(AW),
        .TIMEOUT_CYCLES  (TO),
        .ERR_CNT_WIDTH   (ECW)
    ) dut (
        .axi_aclk     (clk),
        .axi_aresetn  (rst_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_write    (cmd_write),
        .cmd_addr     (cmd_addr),
        .cmd_data     (cmd_data),
        .cmd_strb     (cmd_strb),
        .cmd_mask     (cmd_mask),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_data     (rsp_data),
        .rsp_resp     (rsp_resp),
        .rsp_mismatch (rsp_mismatch),
        .rsp_timeout  (rsp_timeout),
        .busy         (busy),
        .err_count    (err_count),
        .dbg_state    (dbg_state),
        .m_axi_awaddr (awaddr),
        .m_axi_awprot (awprot),
        .m_axi_awvalid(awvalid),
        .m_axi_awready(awready),
        .m_axi_wdata  (wdata),
        .m_axi_wstrb  (wstrb),
        .m_axi_wvalid (wvalid),
        .m_axi_wready (wready),
        .m_axi_bresp  (bresp),
        .m_axi_bvalid (bvalid),
        .m_axi_bready (bready),
        .m_axi_araddr (araddr),
        .m_axi_arprot (arprot),
        .m_axi_arvalid(arvalid),
        .m_axi_arready(arready),
        .m_axi_rdata  (rdata),
        .m_axi_rresp  (rresp),
        .m_axi_rvalid (rvalid),
        .m_axi_rready (rready)
    );

    // ---------------- handshake monitor ----------------
    int aw_hs_n = 0, w_hs_n = 0, b_hs_n = 0;

    always @(posedge clk) begin
        if (awvalid && awready) aw_hs_n <= aw_hs_n + 1;
        if (wvalid && wready)   w_hs_n  <= w_hs_n + 1;
        if (bvalid && bready)   b_hs_n  <= b_hs_n + 1;
    end

    // ---------------- scoreboard ----------------
    logic [DW-1:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(negedge clk);
    endtask

    // Called at a falling edge; returns at the falling edge after acceptance.
    task automatic issue_cmd(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                             input logic [DW/8-1:0] strb, input logic [DW-1:0] mask);
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_data  = data;
        cmd_strb  = strb;
        cmd_mask  = mask;
        cmd_valid = 1'b1;
        check_eq("cmd_ready", cmd_ready, 1'b1);
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic finish_rsp(input string tag, input bit chk_data, input logic [1:0] exp_resp,
                              input logic exp_mis, input logic exp_to, input logic [ECW-1:0] exp_err);
        logic [DW-1:0] exp_data;
        check_eq({tag, "_rsp_valid"}, rsp_valid, 1'b1);
        if (chk_data) begin
            exp_data = exp_q.pop_front();
            check_eq({tag, "_rsp_data"}, rsp_data, exp_data);
        end
        check_eq({tag, "_rsp_resp"}, rsp_resp, exp_resp);
        check_eq({tag, "_mismatch"}, rsp_mismatch, exp_mis);
        check_eq({tag, "_timeout"}, rsp_timeout, exp_to);
        check_eq({tag, "_err_count"}, err_count, exp_err);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check_eq({tag, "_idle_after"}, {rsp_valid, busy, cmd_ready}, 3'b001);
    endtask

    // Slave accepts AW and W immediately, answers B one cycle later.
    task automatic do_write(input string tag, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                            input logic [DW/8-1:0] strb, input logic [1:0] br, input logic [ECW-1:0] exp_err);
        int aw0, w0;
        awready = 1'b1;
        wready  = 1'b1;
        bvalid  = 1'b0;
        exp_q.push_back('0);
        issue_cmd(1'b1, addr, data, strb, '0);
        check_eq({tag, "_aw_w_valid"}, {awvalid, wvalid}, 2'b11);
        check_eq({tag, "_awaddr"}, awaddr, addr);
        check_eq({tag, "_wdata"}, wdata, data);
        check_eq({tag, "_wstrb"}, wstrb, strb);
        aw0 = aw_hs_n;
        w0  = w_hs_n;
        step();
        check_eq({tag, "_aw_w_same_edge"}, {aw_hs_n - aw0, w_hs_n - w0}, {32'd1, 32'd1});
        check_eq({tag, "_valids_dropped"}, {awvalid, wvalid, bready}, 3'b001);
        bvalid = 1'b1;
        bresp  = br;
        step();
        bvalid  = 1'b0;
        awready = 1'b0;
        wready  = 1'b0;
        finish_rsp(tag, 1'b1, br, 1'b0, 1'b0, exp_err);
    endtask

    // Slave accepts AR immediately, returns R one cycle later.
    task automatic do_read(input string tag, input logic [AW-1:0] addr, input logic [DW-1:0] expd,
                           input logic [DW-1:0] mask, input logic [DW-1:0] rd,
                           input logic exp_mis, input logic [ECW-1:0] exp_err);
        arready = 1'b1;
        rvalid  = 1'b0;
        exp_q.push_back(rd);
        issue_cmd(1'b0, addr, expd, '0, mask);
        check_eq({tag, "_arvalid"}, arvalid, 1'b1);
        check_eq({tag, "_araddr"}, araddr, addr);
        step();
        arready = 1'b0;
        check_eq({tag, "_ar_done"}, {arvalid, rready}, 2'b01);
        rvalid = 1'b1;
        rdata  = rd;
        rresp  = OKAY;
        step();
        rvalid = 1'b0;
        finish_rsp(tag, 1'b1, OKAY, exp_mis, 1'b0, exp_err);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int b0;
        rst_n = 1'b0;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_data = '0;
        cmd_strb = '0; cmd_mask = '0; rsp_ready = 1'b0;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
        arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = 2'b00;
        repeat (3) step();

        check_eq("reset_handshakes", {cmd_ready, rsp_valid, awvalid, wvalid, bready, arvalid, rready}, 7'b1000000);
        check_eq("reset_busy", busy, 1'b0);
        check_eq("reset_err_count", err_count, 2'd0);
        check_eq("reset_rsp", {rsp_data, rsp_resp, rsp_mismatch, rsp_timeout}, '0);
        check_eq("reset_state", dbg_state, IDLE);
        rst_n = 1'b1;
        step();

        // Basic write, both channels accepted on the first edge.
        do_write("wr_basic", 16'h2000, 32'h001F_6000, 4'hF, OKAY, 2'd0);
        check_eq("prot_tied", {awprot, arprot}, 6'b0);

        // W accepted three cycles before AW.
        awready = 1'b0;
        wready  = 1'b1;
        exp_q.push_back('0);
        issue_cmd(1'b1, 16'h0040, 32'h1234_5678, 4'h3, '0);
        b0 = b_hs_n;
        step();
        wready = 1'b0;
        check_eq("wr_skew_w_first", {awvalid, wvalid}, 2'b10);
        step();
        step();
        check_eq("wr_skew_aw_pending", {awvalid, wvalid, bready}, 3'b100);
        awready = 1'b1;
        step();
        awready = 1'b0;
        check_eq("wr_skew_aw_done", {awvalid, wvalid, bready}, 3'b001);
        bvalid = 1'b1;
        bresp  = OKAY;
        step();
        bvalid = 1'b0;
        step();
        check_eq("wr_skew_one_b", b_hs_n - b0, 1);
        finish_rsp("wr_skew", 1'b1, OKAY, 1'b0, 1'b0, 2'd0);

        // Reads with compare.
        do_read("rd_match", 16'h0010, 32'h0000_0004, 32'hFFFF_FFFF, 32'h0000_0004, 1'b0, 2'd0);
        do_read("rd_mask_hi", 16'h0020, 32'hAAAA_0000, 32'hFFFF_0000, 32'hAAAA_5555, 1'b0, 2'd0);
        do_read("rd_mask_lo", 16'h0020, 32'hAAAA_0000, 32'h0000_FFFF, 32'hAAAA_5555, 1'b1, 2'd1);

        // Slave never raises arready: watchdog aborts after TO cycles in RD_AR.
        arready = 1'b0;
        issue_cmd(1'b0, 16'h0100, '0, '0, '0);
        check_eq("to_state", dbg_state, RD_AR);
        repeat (TO - 1) step();
        check_eq("to_before_limit", {arvalid, rsp_valid}, 2'b10);
        step();
        check_eq("to_valids_dropped", {arvalid, rready}, 2'b00);
        finish_rsp("to", 1'b0, SLVERR, 1'b0, 1'b1, 2'd2);
        check_eq("to_back_idle", dbg_state, IDLE);

        // Slave errors push err_count to saturation.
        do_write("wr_slverr", 16'h0044, 32'hDEAD_BEEF, 4'hF, SLVERR, 2'd3);
        do_write("wr_saturate", 16'h0048, 32'h0000_0001, 4'h1, SLVERR, 2'd3);

        // Reset in WR_B with a pending bvalid.
        awready = 1'b1;
        wready  = 1'b1;
        issue_cmd(1'b1, 16'h0050, 32'h5555_AAAA, 4'hF, '0);
        step();
        awready = 1'b0;
        wready  = 1'b0;
        check_eq("rst_mid_in_wr_b", dbg_state, WR_B);
        bvalid = 1'b1;
        rst_n  = 1'b0;
        step();
        check_eq("rst_mid_idle", {busy, cmd_ready, rsp_valid}, 3'b010);
        check_eq("rst_mid_valids", {awvalid, wvalid, bready, arvalid, rready}, 5'b0);
        check_eq("rst_mid_err_count", err_count, 2'd0);
        bvalid = 1'b0;
        rst_n  = 1'b1;
        repeat (2) step();
        check_eq("rst_mid_no_rsp", {rsp_valid, busy}, 2'b00);
        check_eq("scoreboard_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
        $finish;
    end

endmodule
